jk_bank_sequencer: RTL and testbench

Command-driven controller that sequences a bank of WIDTH JK flip-flops, each with a synchronous `rst`, through hold, set, reset and toggle operations. A requester issues one command per valid/ready handshake. The block drives the bank's J/K inputs for a programmed number of iterations and checks the bank's Q feedback after every iteration. It signals completion or mismatch, and can abort a command by resetting the bank.

---
 rtl/jk_bank_sequencer.sv | 151 +++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
// Command-driven controller for a bank of WIDTH JK flip-flops. Each accepted
// command applies one of hold/reset/set/toggle to a masked set of bank bits
// for a programmed number of iterations, checking the bank's Q feedback after
// every iteration. Completion, mismatch and abort are reported on one-cycle
// outputs; an abort clears the bank through its synchronous reset.
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high exactly when the controller is
// idle and never depends on cmd_valid. A requester may hold cmd_valid (with
// stable payload) for any number of cycles; nothing happens until the edge
// where cmd_ready is also high.
module jk_bank_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_mask,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             abort,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             bank_rst,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] q_snapshot,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      APPLY = 3'd1,
      CHECK = 3'd2,
      DONE  = 3'd3,
      ABORT = 3'd4
   } state_t;

   state_t           state;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] mask_r;
   logic [CNT_W-1:0] rem;
   logic             err_r;
   logic [WIDTH-1:0] exp_r;
   logic [WIDTH-1:0] exp_next;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Predicted bank value after one APPLY: masked bits follow the op, the rest keep q_in.
   always_comb begin
      exp_next = q_in;
      case (op_r)
         2'b00:   exp_next = q_in;
         2'b01:   exp_next = q_in & ~mask_r;
         2'b10:   exp_next = q_in | mask_r;
         default: exp_next = q_in ^ mask_r;
      endcase
   end

   // Sequencing FSM: command capture, apply/check iterations, completion and abort.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         op_r       <= 2'b00;
         mask_r     <= '0;
         rem        <= '0;
         err_r      <= 1'b0;
         exp_r      <= '0;
         q_snapshot <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_r   <= cmd_op;
                  mask_r <= cmd_mask;
                  rem    <= cmd_count;
                  state  <= (cmd_count == '0) ? DONE : APPLY;
               end
            end
            APPLY: begin
               if (abort) begin
                  state <= ABORT;
               end else begin
                  exp_r <= exp_next;
                  rem   <= rem - CNT_ONE;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (abort) begin
                  state <= ABORT;
               end else if (q_in != exp_r) begin
                  // A mismatch ends the command; remaining iterations are skipped.
                  err_r <= 1'b1;
                  state <= DONE;
               end else if (rem != '0) begin
                  state <= APPLY;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               q_snapshot <= q_in;
               err_r      <= 1'b0;
               state      <= IDLE;
            end
            ABORT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Bank drive and status pulses, decoded only from registered state and command.
   always_comb begin
      j        = '0;
      k        = '0;
      bank_rst = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state)
         APPLY: begin
            j = mask_r & {WIDTH{op_r[1]}};
            k = mask_r & {WIDTH{op_r[0]}};
         end
         DONE: begin
            done = 1'b1;
            err  = err_r;
         end
         ABORT: begin
            bank_rst = 1'b1;
         end
         default: begin
            j = '0;
         end
      endcase
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Testbench for jk_bank_sequencer: a behavioural JK bank with optional
// stuck-at-0 bits closes the loop; directed scenarios plus randomized commands
// checked cycle by cycle against a timing-rule reference model.
module tb_jk_bank_sequencer;

   localparam int W  = 4;
   localparam int CW = 4;
   localparam int VW = 2 * W + 5;

   logic          clock = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [W-1:0]  cmd_mask;
   logic [CW-1:0] cmd_count;
   logic          abort;
   logic [W-1:0]  q_in;
   logic [W-1:0]  j;
   logic [W-1:0]  k;
   logic          bank_rst;
   logic          busy;
   logic          done;
   logic          err;
   logic [W-1:0]  q_snapshot;
   logic [2:0]    state_dbg;

   // bench-side bank
   logic [W-1:0]  bank_q;
   logic [W-1:0]  stuck0;
   logic [W-1:0]  load_val;
   logic          bank_load;

   // per-cycle observations, index = cycle number after the handshake edge
   logic [W-1:0]  obs_j    [0:63];
   logic [W-1:0]  obs_k    [0:63];
   logic          obs_brst [0:63];
   logic          obs_done [0:63];
   logic          obs_err  [0:63];
   logic          obs_rdy  [0:63];
   logic          obs_busy [0:63];

   // scoreboard
   logic [VW-1:0] exp_q[$];
   logic [W-1:0]  m_bank;
   logic [W-1:0]  m_snap;

   int n_vec = 0;
   int n_err = 0;

   jk_bank_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
      .clock      (clock),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_mask   (cmd_mask),
      .cmd_count  (cmd_count),
      .abort      (abort),
      .q_in       (q_in),
      .j          (j),
      .k          (k),
      .bank_rst   (bank_rst),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .q_snapshot (q_snapshot),
      .state_dbg  (state_dbg)
   );

   // clock
   always #5 clock = ~clock;

   // JK bank with synchronous reset and a bench-only load path; stuck bits read as 0
   always @(posedge clock) begin
      if (bank_load)     bank_q <= load_val;
      else if (bank_rst) bank_q <= '0;
      else               bank_q <= (j & ~bank_q) | (~k & bank_q);
   end
   assign q_in = bank_q & ~stuck0;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [W-1:0] apply_op(input logic [1:0] op, input logic [W-1:0] mask,
                                             input logic [W-1:0] q);
      case (op)
         2'b00:   return q;
         2'b01:   return q & ~mask;
         2'b10:   return q | mask;
         default: return q ^ mask;
      endcase
   endfunction

   // ---------------- driver tasks (called #1 after an edge, return #1 after an edge)
   task automatic load_bank(input logic [W-1:0] v);
      bank_load = 1'b1;
      load_val  = v;
      @(posedge clock);
      #1;
      bank_load = 1'b0;
   endtask

   // Presents a command; returns at the handshake edge (edge 0).
   task automatic start_cmd(input logic [1:0] op, input logic [W-1:0] mask, input logic [CW-1:0] cnt);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_mask  = mask;
      cmd_count = cnt;
      @(posedge clock);
   endtask

   // Records cycles 1..len; abort is high during cycle abort_c; cmd_valid follows hold.
   task automatic observe(input int len, input int abort_c, input logic hold);
      for (int n = 1; n <= len; n++) begin
         #1;
         cmd_valid = hold;
         abort     = (n == abort_c);
         #2;
         obs_j[n]    = j;
         obs_k[n]    = k;
         obs_brst[n] = bank_rst;
         obs_done[n] = done;
         obs_err[n]  = err;
         obs_rdy[n]  = cmd_ready;
         obs_busy[n] = busy;
         @(posedge clock);
      end
      #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
   endtask

   // ---------------- reference model
   // Walks iterations by the documented cycle rules: iteration i applies in cycle
   // 2i-1 and is checked in cycle 2i; the command ends in a done cycle or, on abort
   // in cycle c, with bank reset in c+1 and readiness in c+2.
   task automatic model_cmd(input logic [1:0] op, input logic [W-1:0] mask, input int cnt,
                            input logic [W-1:0] start_b, input logic [W-1:0] s,
                            input int abort_c, output int len);
      logic [W-1:0] b;
      logic [W-1:0] qa;
      logic [W-1:0] jv;
      logic [W-1:0] kv;
      logic         e_flag;
      bit           ab;
      int           term;
      b      = start_b;
      e_flag = 1'b0;
      ab     = 1'b0;
      jv     = mask & {W{op[1]}};
      kv     = mask & {W{op[0]}};
      term   = 2 * cnt + 1;
      for (int i = 1; i <= cnt; i++) begin
         qa = b & ~s;
         b  = apply_op(op, mask, b);
         if (abort_c == 2 * i - 1) begin ab = 1'b1; term = 2 * i - 1; break; end
         if (abort_c == 2 * i)     begin ab = 1'b1; term = 2 * i;     break; end
         if ((b & ~s) != apply_op(op, mask, qa)) begin
            e_flag = 1'b1;
            term   = 2 * i + 1;
            break;
         end
      end
      len = ab ? term + 2 : term + 1;
      for (int n = 1; n <= len; n++) begin
         logic [W-1:0] ej;
         logic [W-1:0] ek;
         logic er, ed, ee, ery;
         ej = '0; ek = '0; er = 1'b0; ed = 1'b0; ee = 1'b0;
         ery = (n == len);
         if ((n % 2) == 1 && (ab ? n <= term : n < term)) begin
            ej = jv;
            ek = kv;
         end
         if (!ab && n == term) begin ed = 1'b1; ee = e_flag; end
         if (ab && n == term + 1) er = 1'b1;
         exp_q.push_back({ej, ek, er, ed, ee, ery, ~ery});
      end
      if (ab) b = '0;
      else    m_snap = b & ~s;
      m_bank = b;
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      load_bank(4'b0011);
      start_cmd(2'b10, 4'b1100, 4'd2);
      #1;
      cmd_valid = 1'b0;
      n_vec++;
      if (j !== 4'b1100) begin n_err++; $display("FAIL reset_pre_apply_j: got %b want 1100", j); end
      rst = 1'b1;
      #1;
      n_vec++;
      if (j !== 4'b0000 || k !== 4'b0000) begin
         n_err++; $display("FAIL reset_jk: got j=%b k=%b want 0000/0000", j, k);
      end
      n_vec++;
      if (bank_rst !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ctrl: got bank_rst=%b busy=%b ready=%b want 0/0/1", bank_rst, busy, cmd_ready);
      end
      n_vec++;
      if (done !== 1'b0 || err !== 1'b0 || q_snapshot !== 4'b0000) begin
         n_err++; $display("FAIL reset_status: got done=%b err=%b snap=%b want 0/0/0000", done, err, q_snapshot);
      end
      @(posedge clock);
      #1;
      n_vec++;
      if (bank_q !== 4'b0011) begin n_err++; $display("FAIL reset_bank_kept: got %b want 0011", bank_q); end
      rst = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_set();
      load_bank(4'b0000);
      start_cmd(2'b10, 4'b0101, 4'd1);
      observe(4, 0, 1'b0);
      n_vec++;
      if (obs_j[1] !== 4'b0101 || obs_k[1] !== 4'b0000) begin
         n_err++; $display("FAIL set_jk_c1: got j=%b k=%b want 0101/0000", obs_j[1], obs_k[1]);
      end
      n_vec++;
      if (obs_done[2] !== 1'b0 || obs_done[3] !== 1'b1 || obs_err[3] !== 1'b0) begin
         n_err++; $display("FAIL set_done: got done2=%b done3=%b err3=%b want 0/1/0", obs_done[2], obs_done[3], obs_err[3]);
      end
      n_vec++;
      if (q_snapshot !== 4'b0101) begin n_err++; $display("FAIL set_snapshot: got %b want 0101", q_snapshot); end
      n_vec++;
      if (obs_rdy[3] !== 1'b0 || obs_rdy[4] !== 1'b1) begin
         n_err++; $display("FAIL set_ready: got c3=%b c4=%b want 0/1", obs_rdy[3], obs_rdy[4]);
      end
   endtask

   task automatic test_toggle_back_to_back();
      load_bank(4'b0000);
      start_cmd(2'b11, 4'b1111, 4'd3);
      observe(8, 0, 1'b1);
      for (int c = 1; c <= 5; c += 2) begin
         n_vec++;
         if (obs_j[c] !== 4'b1111 || obs_k[c] !== 4'b1111) begin
            n_err++; $display("FAIL toggle_jk_c%0d: got j=%b k=%b want 1111/1111", c, obs_j[c], obs_k[c]);
         end
      end
      n_vec++;
      if (obs_done[6] !== 1'b0 || obs_done[7] !== 1'b1) begin
         n_err++; $display("FAIL toggle_done: got c6=%b c7=%b want 0/1", obs_done[6], obs_done[7]);
      end
      for (int c = 1; c <= 7; c++) begin
         n_vec++;
         if (obs_rdy[c] !== 1'b0) begin n_err++; $display("FAIL toggle_busy_ready_c%0d: got %b want 0", c, obs_rdy[c]); end
      end
      n_vec++;
      if (obs_rdy[8] !== 1'b1) begin n_err++; $display("FAIL toggle_ready_c8: got %b want 1", obs_rdy[8]); end
      n_vec++;
      if (q_snapshot !== 4'b1111) begin n_err++; $display("FAIL toggle_snapshot: got %b want 1111", q_snapshot); end
      // the held cmd_valid is taken at edge 8: the second command starts now
      observe(8, 0, 1'b0);
      n_vec++;
      if (obs_j[1] !== 4'b1111 || obs_done[7] !== 1'b1) begin
         n_err++; $display("FAIL b2b_second_cmd: got j1=%b done7=%b want 1111/1", obs_j[1], obs_done[7]);
      end
      n_vec++;
      if (q_snapshot !== 4'b0000) begin n_err++; $display("FAIL b2b_snapshot: got %b want 0000", q_snapshot); end
   endtask

   task automatic test_zero_count();
      load_bank(4'b1010);
      start_cmd(2'b01, 4'b1111, 4'd0);
      observe(2, 0, 1'b0);
      n_vec++;
      if (obs_done[1] !== 1'b1 || obs_err[1] !== 1'b0) begin
         n_err++; $display("FAIL zero_done_c1: got done=%b err=%b want 1/0", obs_done[1], obs_err[1]);
      end
      n_vec++;
      if ((obs_j[1] | obs_k[1] | obs_j[2] | obs_k[2]) !== 4'b0000) begin
         n_err++; $display("FAIL zero_jk: got j1=%b k1=%b j2=%b k2=%b want all 0", obs_j[1], obs_k[1], obs_j[2], obs_k[2]);
      end
      n_vec++;
      if (obs_rdy[1] !== 1'b0 || obs_rdy[2] !== 1'b1) begin
         n_err++; $display("FAIL zero_ready: got c1=%b c2=%b want 0/1", obs_rdy[1], obs_rdy[2]);
      end
      n_vec++;
      if (bank_q !== 4'b1010 || q_snapshot !== 4'b1010) begin
         n_err++; $display("FAIL zero_bank_snap: got bank=%b snap=%b want 1010/1010", bank_q, q_snapshot);
      end
   endtask

   task automatic test_abort();
      load_bank(4'b0000);
      start_cmd(2'b11, 4'b1111, 4'd5);
      observe(6, 4, 1'b0);
      n_vec++;
      if (obs_brst[4] !== 1'b0 || obs_brst[5] !== 1'b1 || obs_brst[6] !== 1'b0) begin
         n_err++; $display("FAIL abort_bank_rst: got c4=%b c5=%b c6=%b want 0/1/0", obs_brst[4], obs_brst[5], obs_brst[6]);
      end
      for (int c = 1; c <= 6; c++) begin
         n_vec++;
         if (obs_done[c] !== 1'b0 || obs_err[c] !== 1'b0) begin
            n_err++; $display("FAIL abort_no_done_c%0d: got done=%b err=%b want 0/0", c, obs_done[c], obs_err[c]);
         end
      end
      n_vec++;
      if (obs_rdy[5] !== 1'b0 || obs_rdy[6] !== 1'b1) begin
         n_err++; $display("FAIL abort_ready: got c5=%b c6=%b want 0/1", obs_rdy[5], obs_rdy[6]);
      end
      n_vec++;
      if (obs_j[5] !== 4'b0000 || obs_k[5] !== 4'b0000) begin
         n_err++; $display("FAIL abort_jk_c5: got j=%b k=%b want 0000/0000", obs_j[5], obs_k[5]);
      end
      n_vec++;
      if (bank_q !== 4'b0000 || q_snapshot !== 4'b1010) begin
         n_err++; $display("FAIL abort_bank_snap: got bank=%b snap=%b want 0000/1010", bank_q, q_snapshot);
      end
   endtask

   task automatic test_fault();
      load_bank(4'b0000);
      stuck0 = 4'b0001;
      start_cmd(2'b10, 4'b0001, 4'd3);
      observe(4, 0, 1'b0);
      n_vec++;
      if (obs_done[3] !== 1'b1 || obs_err[3] !== 1'b1) begin
         n_err++; $display("FAIL fault_done_err_c3: got done=%b err=%b want 1/1", obs_done[3], obs_err[3]);
      end
      n_vec++;
      if (obs_j[1] !== 4'b0001 || obs_j[3] !== 4'b0000) begin
         n_err++; $display("FAIL fault_apply: got j1=%b j3=%b want 0001/0000", obs_j[1], obs_j[3]);
      end
      n_vec++;
      if (obs_rdy[4] !== 1'b1 || q_snapshot[0] !== 1'b0) begin
         n_err++; $display("FAIL fault_end: got ready4=%b snap0=%b want 1/0", obs_rdy[4], q_snapshot[0]);
      end
      stuck0 = '0;
   endtask

   task automatic test_random();
      logic [1:0]   op;
      logic [W-1:0] mask;
      logic [W-1:0] sb;
      logic [W-1:0] s;
      int           cnt;
      int           ab_c;
      int           len;
      logic [VW-1:0] e;
      // clear the snapshot so the model starts from a known value
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clock);
      #1;
      m_snap = '0;
      for (int t = 0; t < 30; t++) begin
         op   = 2'($urandom_range(0, 3));
         mask = 4'($urandom_range(0, 15));
         sb   = 4'($urandom_range(0, 15));
         cnt  = $urandom_range(0, 9);
         s    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         ab_c = (cnt > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * cnt) : 0;
         stuck0 = s;
         load_bank(sb);
         model_cmd(op, mask, cnt, sb, s, ab_c, len);
         start_cmd(op, mask, CW'(cnt));
         observe(len, ab_c, 1'b0);
         for (int n = 1; n <= len; n++) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({obs_j[n], obs_k[n], obs_brst[n], obs_done[n], obs_err[n], obs_rdy[n], obs_busy[n]} !== e) begin
               n_err++;
               $display("FAIL rand_cycle: cmd %0d op=%b mask=%b cnt=%0d abort@%0d cycle %0d got j,k,brst,done,err,rdy,busy=%b,%b,%b%b%b%b%b want %b,%b,%b (state %0d)",
                        t, op, mask, cnt, ab_c, n, obs_j[n], obs_k[n], obs_brst[n], obs_done[n], obs_err[n],
                        obs_rdy[n], obs_busy[n], e[VW-1 -: W], e[VW-1-W -: W], e[4:0], state_dbg);
            end
         end
         n_vec++;
         if (q_snapshot !== m_snap) begin
            n_err++; $display("FAIL rand_snapshot: cmd %0d got %b want %b", t, q_snapshot, m_snap);
         end
         n_vec++;
         if (bank_q !== m_bank) begin
            n_err++; $display("FAIL rand_bank: cmd %0d got %b want %b", t, bank_q, m_bank);
         end
         stuck0 = '0;
      end
   endtask

   // ---------------- main sequence and report
   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_mask  = '0;
      cmd_count = '0;
      abort     = 1'b0;
      stuck0    = '0;
      bank_load = 1'b1;
      load_val  = '0;
      repeat (2) @(posedge clock);
      #1;
      bank_load = 1'b0;
      rst       = 1'b0;
      @(posedge clock);
      #1;
      test_reset();
      test_set();
      test_toggle_back_to_back();
      test_zero_count();
      test_abort();
      test_fault();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
